slope_adc_ctrl: RTL
===================

SLOPE_ADC_CTRL -- requirements
Module: slope_adc_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the ramp counter and result width (4..16).
REQ-002 Parameter RST_CYC, default 4, SHALL set the number of capacitor-discharge cycles per conversion (1..255).
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the comparator synchroniser depth (2..4).
REQ-004 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  continuous-conversion enable.
REQ-007 cmp  in  1  asynchronous comparator output; high = ramp crossed threshold.
REQ-008 cap_rst  out  1  analog capacitor discharge switch; 1 = discharging.
REQ-009 dout  out  WIDTH  last conversion result.
REQ-010 valid  out  1  one-cycle pulse; dout/ovf are new.
REQ-011 ovf  out  1  last result saturated (no comparator trip).
REQ-012 busy  out  1  high in DISCHARGE and RAMP.

Function
REQ-013 cmp SHALL pass through SYNC_STAGES flops; cmp_s, the last stage, is the only internal use of cmp.
REQ-014 The FSM SHALL have states IDLE, DISCHARGE, RAMP.
REQ-015 IDLE: cap_rst=1, busy=0; en=1 -> DISCHARGE next cycle.
REQ-016 DISCHARGE: cap_rst=1, busy=1, lasting exactly RST_CYC cycles, then RAMP with the counter at 0.
REQ-017 RAMP: cap_rst=0, busy=1; the counter SHALL be 0 in the first RAMP cycle and increment by 1 each cycle.
REQ-018 In a RAMP cycle with cmp_s=1, dout SHALL take the current counter value, ovf SHALL take 0, and the FSM SHALL go to DISCHARGE if en=1, else IDLE.
REQ-019 In a RAMP cycle with the counter at 2^WIDTH-1 and cmp_s=0, dout SHALL take 2^WIDTH-1, ovf SHALL take 1, and the counter SHALL NOT wrap.
REQ-020 If cmp_s=1 and the counter is at its maximum in the same cycle, the comparator SHALL win, with ovf=0.
REQ-021 valid SHALL pulse high for exactly one cycle, in the cycle after capture, coincident with the updated dout/ovf.
REQ-022 Pin-to-valid latency: cmp high from RAMP cycle k SHALL give dout=k+SYNC_STAGES and valid SHALL be seen in RAMP cycle k+SYNC_STAGES+1.
REQ-023 en=0 during DISCHARGE or RAMP SHALL abort to IDLE next cycle, with no valid and dout/ovf unchanged.
REQ-024 dout and ovf SHALL hold between valid pulses.

Reset
REQ-025 rst SHALL force state=IDLE, counter=0, synchroniser=0, cap_rst=1, dout=0, valid=0, ovf=0, busy=0.
REQ-026 rst mid-conversion SHALL abort the conversion with no valid pulse; rst SHALL take priority over en and cmp.

Configuration
REQ-027 Macro SLOPE_ADC_AVG_EN defined: four consecutive conversions SHALL be summed in a WIDTH+2-bit accumulator, with dout = sum>>2 (truncated) and valid once per 4 conversions.
REQ-028 With SLOPE_ADC_AVG_EN defined, ovf SHALL be the OR of the four ovf values in the group, and abort or rst SHALL clear the accumulator and group count.
REQ-029 Macro SLOPE_ADC_AVG_EN undefined: there SHALL be no accumulator, and every conversion SHALL produce valid.

Verification (WIDTH=8, RST_CYC=4, SYNC_STAGES=2)
REQ-030 en=1, cmp high from RAMP cycle 50 -> dout=52, ovf=0, one valid pulse, cap_rst=1 for the next 4 cycles.
REQ-031 en=1, cmp held 0 -> after 256 RAMP cycles dout=255, ovf=1, valid once, then a new DISCHARGE.
REQ-032 cmp stuck 1, en=1 -> every conversion dout=0, ovf=0, valid every RST_CYC+1 cycles.
REQ-033 en dropped at RAMP cycle 20 -> no valid, cap_rst=1 and busy=0 from the next cycle, dout unchanged.
REQ-034 rst asserted at RAMP cycle 30 -> all outputs at reset values next cycle; a restart with en=1 gives a normal conversion.
REQ-035 SLOPE_ADC_AVG_EN, results 10, 20, 30, 41 -> single valid with dout=25, ovf=0.

Source files
------------

// File: rtl/slope_adc_ctrl_if.sv
// Control/data bundle between the slope ADC controller and its analog front end.
// The controller takes the slave modport; whoever drives en/cmp takes master.
interface slope_adc_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             cmp;
   logic             cap_rst;
   logic [WIDTH-1:0] dout;
   logic             valid;
   logic             ovf;
   logic             busy;

   modport master (
      output en, cmp,
      input  cap_rst, dout, valid, ovf, busy
   );

   modport slave (
      input  en, cmp,
      output cap_rst, dout, valid, ovf, busy
   );
endinterface

// File: rtl/slope_adc_ctrl.sv
// Single-slope ADC controller: discharge, ramp count, comparator capture.
// Define SLOPE_ADC_AVG_EN to report the average of every four conversions.
module slope_adc_ctrl #(
   parameter int WIDTH       = 8,
   parameter int RST_CYC     = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic            clk,
   input logic            rst,
   slope_adc_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DISCHARGE, RAMP} state_t;

   localparam logic [WIDTH-1:0] MAX   = '1;
   localparam logic [7:0]       DLAST = 8'(RST_CYC - 1);

   state_t state, nxt;

   logic [SYNC_STAGES-1:0] sync;
   logic                   cmp_s;
   logic [WIDTH-1:0]       cnt;
   logic [7:0]             dcnt;
   logic                   cap;
   logic [WIDTH-1:0]       dout_q;
   logic                   ovf_q;
   logic                   valid_q;

   assign cmp_s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sync  <= '0;
         cnt   <= '0;
         dcnt  <= '0;
      end else begin
         state <= nxt;
         sync  <= {sync[SYNC_STAGES-2:0], bus.cmp};
         cnt   <= (state == RAMP && nxt == RAMP) ? cnt + 1'b1 : '0;
         dcnt  <= (state == DISCHARGE && nxt == DISCHARGE) ? dcnt + 8'd1 : 8'd0;
      end
   end

   // A capture in the same cycle as en=0 still reports; en only picks the next state.
   always_comb begin
      nxt = state;
      cap = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.en) nxt = DISCHARGE;
         end
         DISCHARGE: begin
            if (!bus.en) nxt = IDLE;
            else if (dcnt == DLAST) nxt = RAMP;
         end
         RAMP: begin
            if (cmp_s || cnt == MAX) begin
               cap = 1'b1;
               nxt = bus.en ? DISCHARGE : IDLE;
            end else if (!bus.en) begin
               nxt = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

`ifdef SLOPE_ADC_AVG_EN
   logic [WIDTH+1:0] acc;
   logic [WIDTH+1:0] sum;
   logic [1:0]       grp;
   logic             ovf_acc;
   logic             abort;

   assign sum   = acc + {2'b00, cnt};
   assign abort = (state != IDLE) && !bus.en && !cap;

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         acc     <= '0;
         grp     <= 2'd0;
         ovf_acc <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (cap) begin
            if (grp == 2'd3) begin
               dout_q  <= sum[WIDTH+1:2];
               ovf_q   <= ovf_acc | ~cmp_s;
               valid_q <= 1'b1;
               acc     <= '0;
               grp     <= 2'd0;
               ovf_acc <= 1'b0;
            end else begin
               acc     <= sum;
               grp     <= grp + 2'd1;
               ovf_acc <= ovf_acc | ~cmp_s;
            end
         end else if (abort) begin
            acc     <= '0;
            grp     <= 2'd0;
            ovf_acc <= 1'b0;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= cap;
         if (cap) begin
            dout_q <= cnt;
            ovf_q  <= ~cmp_s;
         end
      end
   end
`endif

   assign bus.cap_rst = (state != RAMP);
   assign bus.busy    = (state != IDLE);
   assign bus.dout    = dout_q;
   assign bus.ovf     = ovf_q;
   assign bus.valid   = valid_q;
endmodule
